// File: rtl/dsp_cascade_pipe_ctrl.sv
// Pipeline controller for a DSP cascade-adder chain: shared clken/dsp_reset, in-flight tracking, flush.
// Define DSP_CASCADE_PERF_CNT_EN to add the perf_beats/perf_stalls counters.
module dsp_cascade_pipe_ctrl #(
  parameter int STAGES        = 4,
  parameter int HEAD_LATENCY  = 3,
  parameter int STAGE_LATENCY = 1,
  parameter int RST_HOLD      = 4,
  localparam int LAT          = HEAD_LATENCY + (STAGES - 1) * STAGE_LATENCY,
  localparam int OCC_W        = $clog2(LAT + 1)
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              m_valid,
  input  logic              m_ready,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              clken,
  output logic              dsp_reset,
  output logic [STAGES-1:0] stage_load,
  output logic [OCC_W-1:0]  occupancy
`ifdef DSP_CASCADE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_beats,
  output logic [31:0]       perf_stalls
`endif
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic [1:0] {HOLD, RUN, DRAIN, IDLE_FLUSHED} state_t;

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic              from_flush, from_flush_nxt;
  logic [LAT-1:0]    vsr, vsr_shifted;
  logic [OCC_W-1:0]  occ;
  logic              running, stall, advance, accept, xfer;

  assign running = (state == RUN) || (state == DRAIN);
  assign stall   = running & vsr[LAT-1] & ~m_ready;
  assign advance = aresetn & running & ~stall;
  assign accept  = s_valid & s_ready;
  assign xfer    = m_valid & m_ready;
  assign occupancy = occ;

  if (LAT == 1) begin : g_vsr_one
    assign vsr_shifted = accept;
  end else begin : g_vsr_many
    assign vsr_shifted = {vsr[LAT-2:0], accept};
  end

  // Stage k loads one cycle before its P register captures the beat.
  assign stage_load[0] = accept;
  for (genvar k = 1; k < STAGES; k++) begin : g_load
    localparam int IDX = HEAD_LATENCY - 2 + (k - 1) * STAGE_LATENCY;
    if (IDX >= 0) begin : g_tap
      assign stage_load[k] = vsr[IDX] & advance;
    end else begin : g_direct
      assign stage_load[k] = accept;
    end
  end

  // Outputs are forced to their reset values while aresetn is low.
  always_comb begin
    state_nxt      = state;
    hold_cnt_nxt   = hold_cnt;
    from_flush_nxt = from_flush;
    s_ready        = 1'b0;
    m_valid        = 1'b0;
    flush_done     = 1'b0;
    clken          = 1'b0;
    dsp_reset      = 1'b1;
    if (aresetn) begin
      case (state)
        HOLD: begin
          clken = 1'b1;
          if (hold_cnt == '0) begin
            state_nxt = from_flush ? IDLE_FLUSHED : RUN;
          end else begin
            hold_cnt_nxt = hold_cnt - HOLD_W'(1);
          end
        end
        RUN: begin
          dsp_reset = 1'b0;
          clken     = ~stall;
          m_valid   = vsr[LAT-1];
          s_ready   = ~flush_req & ~stall;
          if (flush_req) state_nxt = DRAIN;
        end
        DRAIN: begin
          dsp_reset = 1'b0;
          clken     = ~stall;
          m_valid   = vsr[LAT-1];
          if (occ == '0) begin
            state_nxt      = HOLD;
            hold_cnt_nxt   = HOLD_W'(RST_HOLD - 1);
            from_flush_nxt = 1'b1;
          end
        end
        IDLE_FLUSHED: begin
          dsp_reset      = 1'b0;
          flush_done     = 1'b1;
          from_flush_nxt = 1'b0;
          state_nxt      = RUN;
        end
        default: state_nxt = HOLD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state      <= HOLD;
      hold_cnt   <= HOLD_W'(RST_HOLD - 1);
      from_flush <= 1'b0;
      vsr        <= '0;
      occ        <= '0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_cnt_nxt;
      from_flush <= from_flush_nxt;
      if (state == HOLD) begin
        vsr <= '0;
        occ <= '0;
      end else begin
        if (advance) vsr <= vsr_shifted;
        if (accept && !xfer) begin
          occ <= occ + OCC_W'(1);
        end else if (xfer && !accept) begin
          occ <= occ - OCC_W'(1);
        end
      end
    end
  end

`ifdef DSP_CASCADE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      perf_beats  <= '0;
      perf_stalls <= '0;
    end else begin
      if (xfer)  perf_beats  <= perf_beats + 32'd1;
      if (stall) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dsp_cascade_pipe_ctrl.sv
// Self-checking bench for dsp_cascade_pipe_ctrl: directed scenarios plus random traffic against a beat-queue model.
module tb_dsp_cascade_pipe_ctrl;

  localparam int STAGES   = 4;
  localparam int HL       = 3;
  localparam int SL       = 1;
  localparam int RST_HOLD = 4;
  localparam int LAT      = HL + (STAGES - 1) * SL;
  localparam int OCC_W    = $clog2(LAT + 1);
  localparam int M_HOLD = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic aresetn, s_valid, m_ready, flush_req;
  logic s_ready, m_valid, flush_done, clken, dsp_reset;
  logic [STAGES-1:0] stage_load;
  logic [OCC_W-1:0]  occupancy;
`ifdef DSP_CASCADE_PERF_CNT_EN
  logic [31:0] perf_beats, perf_stalls;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: operating mode plus a queue of in-flight beats, each
  // holding how many more chain advances it needs before reaching the output.
  int mode      = M_HOLD;
  int hold_left = RST_HOLD;
  bit flushed   = 1'b0;
  int q[$];
  logic exp_mvalid, exp_sready, exp_clken, exp_dsp_reset, exp_fdone;
  logic exp_accept, exp_stall, exp_adv;
  logic [STAGES-1:0] exp_load;
  int exp_occ;
  logic [31:0] mdl_beats = '0;
  logic [31:0] mdl_stalls = '0;

  always #5 clk = ~clk;

  dsp_cascade_pipe_ctrl #(
    .STAGES(STAGES), .HEAD_LATENCY(HL), .STAGE_LATENCY(SL), .RST_HOLD(RST_HOLD)
  ) dut (
    .clk(clk), .aresetn(aresetn), .s_valid(s_valid), .s_ready(s_ready),
    .m_valid(m_valid), .m_ready(m_ready), .flush_req(flush_req),
    .flush_done(flush_done), .clken(clken), .dsp_reset(dsp_reset),
    .stage_load(stage_load), .occupancy(occupancy)
`ifdef DSP_CASCADE_PERF_CNT_EN
    , .perf_beats(perf_beats), .perf_stalls(perf_stalls)
`endif
  );

  task automatic eval_model();
    bit live;
    live       = aresetn && (mode == M_RUN || mode == M_DRAIN);
    exp_mvalid = live && q.size() > 0 && q[0] == 0;
    exp_stall  = exp_mvalid && !m_ready;
    exp_adv    = live && !exp_stall;
    if (!aresetn)            exp_clken = 1'b0;
    else if (mode == M_HOLD) exp_clken = 1'b1;
    else if (mode == M_DONE) exp_clken = 1'b0;
    else                     exp_clken = !exp_stall;
    exp_dsp_reset = !aresetn || mode == M_HOLD;
    exp_sready    = aresetn && mode == M_RUN && !flush_req && !exp_stall;
    exp_accept    = exp_sready && s_valid;
    exp_fdone     = aresetn && mode == M_DONE;
    exp_occ       = q.size();
    exp_load      = '0;
    exp_load[0]   = exp_accept;
    for (int k = 1; k < STAGES; k++)
      foreach (q[i])
        if (exp_adv && q[i] == LAT - (HL - 1 + (k - 1) * SL)) exp_load[k] = 1'b1;
  endtask

  task automatic commit();
    bit was_empty;
    was_empty = (q.size() == 0);
    if (!aresetn) begin
      mode = M_HOLD; hold_left = RST_HOLD; flushed = 1'b0; q.delete();
      mdl_beats = '0; mdl_stalls = '0;
      return;
    end
    if (exp_mvalid && m_ready) mdl_beats = mdl_beats + 32'd1;
    if (exp_stall) mdl_stalls = mdl_stalls + 32'd1;
    case (mode)
      M_HOLD: begin
        q.delete();
        hold_left--;
        if (hold_left == 0) mode = flushed ? M_DONE : M_RUN;
      end
      M_RUN, M_DRAIN: begin
        if (exp_adv) begin
          if (exp_mvalid && m_ready) q.delete(0);
          foreach (q[i]) q[i]--;
          if (exp_accept) q.push_back(LAT - 1);
        end
        if (mode == M_RUN && flush_req) mode = M_DRAIN;
        else if (mode == M_DRAIN && was_empty) begin
          mode = M_HOLD; hold_left = RST_HOLD; flushed = 1'b1;
        end
      end
      default: begin mode = M_RUN; flushed = 1'b0; end
    endcase
  endtask

  task automatic settle();
    @(negedge clk);
    eval_model();
  endtask

  task automatic advance();
    commit();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; s_valid = 1'b0; m_ready = 1'b1; flush_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      total++;
      if (dsp_reset !== 1'b1 || clken !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b0 || flush_done !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_outputs: dsp_reset=%b clken=%b m_valid=%b s_ready=%b flush_done=%b, required 1 0 0 0 0",
                 dsp_reset, clken, m_valid, s_ready, flush_done);
      end
      if (i == 1) begin
        total++;
        if (occupancy !== '0 || stage_load !== '0) begin
          bad++;
          $display("[TB] FAIL reset_state: occupancy=%0d stage_load=%b, required 0 0", occupancy, stage_load);
        end
      end
      advance();
    end
    aresetn = 1'b1;
    for (int c = 0; c <= RST_HOLD; c++) begin
      settle();
      total++;
      if (dsp_reset !== (c < RST_HOLD)) begin
        bad++;
        $display("[TB] FAIL reset_hold cycle %0d: dsp_reset=%b, required %b", c, dsp_reset, c < RST_HOLD);
      end
      total++;
      if (s_ready !== (c == RST_HOLD)) begin
        bad++;
        $display("[TB] FAIL reset_sready cycle %0d: s_ready=%b, required %b", c, s_ready, c == RST_HOLD);
      end
      total++;
      if (m_valid !== 1'b0 || occupancy !== '0) begin
        bad++;
        $display("[TB] FAIL reset_idle cycle %0d: m_valid=%b occupancy=%0d, required 0 0", c, m_valid, occupancy);
      end
      advance();
    end
  endtask

  task automatic test_single_beat();
    int off;
    m_ready = 1'b1;
    for (int c = 0; c < LAT + 3; c++) begin
      s_valid = (c == 0);
      settle();
      total++;
      if (m_valid !== (c == LAT)) begin
        bad++;
        $display("[TB] FAIL single_mvalid cycle %0d: m_valid=%b, required %b", c, m_valid, c == LAT);
      end
      total++;
      if (stage_load[0] !== (c == 0)) begin
        bad++;
        $display("[TB] FAIL single_load0 cycle %0d: got %b, required %b", c, stage_load[0], c == 0);
      end
      for (int k = 1; k < STAGES; k++) begin
        off = HL - 1 + (k - 1) * SL;
        total++;
        if (stage_load[k] !== (c == off)) begin
          bad++;
          $display("[TB] FAIL single_load%0d cycle %0d: got %b, required %b", k, c, stage_load[k], c == off);
        end
      end
      advance();
    end
    s_valid = 1'b0;
  endtask

  task automatic test_stream();
    int seen = 0, first = -1, last = -1, peak = 0;
    m_ready = 1'b1;
    for (int c = 0; c < 20 + LAT + 3; c++) begin
      s_valid = (c < 20);
      settle();
      total++;
      if (m_valid !== exp_mvalid) begin
        bad++;
        $display("[TB] FAIL stream_mvalid cycle %0d: m_valid=%b, required %b", c, m_valid, exp_mvalid);
      end
      total++;
      if (occupancy !== OCC_W'(exp_occ)) begin
        bad++;
        $display("[TB] FAIL stream_occ cycle %0d: occupancy=%0d, required %0d", c, occupancy, exp_occ);
      end
      if (m_valid === 1'b1) begin
        seen++;
        if (first < 0) first = c;
        last = c;
      end
      if (int'(occupancy) > peak) peak = int'(occupancy);
      advance();
    end
    s_valid = 1'b0;
    total++;
    if (seen != 20 || first != LAT || last - first + 1 != 20) begin
      bad++;
      $display("[TB] FAIL stream_beats: count=%0d first=%0d last=%0d, required 20 %0d %0d", seen, first, last, LAT, LAT + 19);
    end
    total++;
    if (peak != LAT) begin
      bad++;
      $display("[TB] FAIL stream_peak: peak occupancy=%0d, required %0d", peak, LAT);
    end
  endtask

  task automatic test_backpressure();
    int sent = 0, got = 0;
    bit held;
`ifdef DSP_CASCADE_PERF_CNT_EN
    logic [31:0] st0, bt0;
    st0 = perf_stalls; bt0 = perf_beats;
`endif
    for (int c = 0; c < 60 && got < 8; c++) begin
      held    = (c >= LAT && c < LAT + 3);
      s_valid = (sent < 8);
      m_ready = !held;
      settle();
      total++;
      if (m_valid !== exp_mvalid || s_ready !== exp_sready || clken !== exp_clken) begin
        bad++;
        $display("[TB] FAIL bp_model cycle %0d: m_valid=%b s_ready=%b clken=%b, required %b %b %b",
                 c, m_valid, s_ready, clken, exp_mvalid, exp_sready, exp_clken);
      end
      if (held) begin
        total++;
        if (clken !== 1'b0 || s_ready !== 1'b0 || m_valid !== 1'b1) begin
          bad++;
          $display("[TB] FAIL bp_hold cycle %0d: clken=%b s_ready=%b m_valid=%b, required 0 0 1", c, clken, s_ready, m_valid);
        end
      end
      if (exp_accept) sent++;
      if (m_valid === 1'b1 && m_ready) got++;
      advance();
    end
    s_valid = 1'b0; m_ready = 1'b1;
    total++;
    if (got != 8 || sent != 8) begin
      bad++;
      $display("[TB] FAIL bp_count: sent=%0d delivered=%0d, required 8 8", sent, got);
    end
`ifdef DSP_CASCADE_PERF_CNT_EN
    total++;
    if (perf_stalls - st0 !== 32'd3 || perf_beats - bt0 !== 32'd8) begin
      bad++;
      $display("[TB] FAIL bp_perf: stalls=%0d beats=%0d, required 3 8", perf_stalls - st0, perf_beats - bt0);
    end
`endif
  endtask

  task automatic test_flush();
    int results = 0, pulses = 0, resets = 0, done_at = -1;
    bit resumed = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 60 && !resumed; c++) begin
      s_valid   = (c <= 5);
      flush_req = (c >= 4 && c < 7);
      settle();
      total++;
      if (s_ready !== exp_sready || m_valid !== exp_mvalid || dsp_reset !== exp_dsp_reset ||
          flush_done !== exp_fdone || clken !== exp_clken) begin
        bad++;
        $display("[TB] FAIL flush_model cycle %0d: s_ready=%b m_valid=%b dsp_reset=%b flush_done=%b clken=%b, required %b %b %b %b %b",
                 c, s_ready, m_valid, dsp_reset, flush_done, clken, exp_sready, exp_mvalid, exp_dsp_reset, exp_fdone, exp_clken);
      end
      if (c == 4) begin
        total++;
        if (s_ready !== 1'b0) begin
          bad++;
          $display("[TB] FAIL flush_block: s_ready=%b with flush_req, required 0", s_ready);
        end
      end
      if (c >= 4 && m_valid === 1'b1) results++;
      if (dsp_reset === 1'b1) resets++;
      if (flush_done === 1'b1) begin pulses++; if (done_at < 0) done_at = c; end
      if (done_at >= 0 && c == done_at + 1) begin
        resumed = 1'b1;
        total++;
        if (s_ready !== 1'b1) begin
          bad++;
          $display("[TB] FAIL flush_resume: s_ready=%b, required 1", s_ready);
        end
      end
      advance();
    end
    s_valid = 1'b0; flush_req = 1'b0;
    total++;
    if (results != 4 || pulses != 1 || resets != RST_HOLD || !resumed) begin
      bad++;
      $display("[TB] FAIL flush_summary: results=%0d pulses=%0d reset_cycles=%0d resumed=%0b, required 4 1 %0d 1",
               results, pulses, resets, resumed, RST_HOLD);
    end
  endtask

  task automatic test_flush_empty();
    s_valid = 1'b0; m_ready = 1'b1;
    for (int c = 0; c <= RST_HOLD + 3; c++) begin
      flush_req = (c == 0);
      settle();
      total++;
      if (flush_done !== (c == RST_HOLD + 2)) begin
        bad++;
        $display("[TB] FAIL empty_done cycle %0d: flush_done=%b, required %b", c, flush_done, c == RST_HOLD + 2);
      end
      total++;
      if (dsp_reset !== (c >= 2 && c < 2 + RST_HOLD)) begin
        bad++;
        $display("[TB] FAIL empty_reset cycle %0d: dsp_reset=%b, required %b", c, dsp_reset, c >= 2 && c < 2 + RST_HOLD);
      end
      total++;
      if (s_ready !== (c == RST_HOLD + 3)) begin
        bad++;
        $display("[TB] FAIL empty_sready cycle %0d: s_ready=%b, required %b", c, s_ready, c == RST_HOLD + 3);
      end
      advance();
    end
    flush_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      s_valid = 1'b1;
      settle();
      advance();
    end
    s_valid = 1'b0; aresetn = 1'b0;
    settle();
    total++;
    if (occupancy !== OCC_W'(exp_occ) || exp_occ != 5) begin
      bad++;
      $display("[TB] FAIL midrst_pre: occupancy=%0d, required 5", occupancy);
    end
    advance();
    aresetn = 1'b1;
    settle();
    total++;
    if (m_valid !== 1'b0 || occupancy !== '0 || dsp_reset !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midrst_after: m_valid=%b occupancy=%0d dsp_reset=%b, required 0 0 1", m_valid, occupancy, dsp_reset);
    end
    advance();
    for (int c = 0; c < 20; c++) begin
      settle();
      total++;
      if (m_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL midrst_stale cycle %0d: m_valid=%b, required 0", c, m_valid);
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      s_valid = ($urandom_range(0, 99) < 60);
      m_ready = ($urandom_range(0, 99) < 70);
      if (flush_req) flush_req = ($urandom_range(0, 99) < 50);
      else           flush_req = ($urandom_range(0, 99) < 3);
      aresetn = ($urandom_range(0, 199) != 0);
      settle();
      total++;
      if (s_ready !== exp_sready || m_valid !== exp_mvalid || clken !== exp_clken) begin
        bad++;
        $display("[TB] FAIL rand_hs cycle %0d: s_ready=%b m_valid=%b clken=%b, required %b %b %b",
                 c, s_ready, m_valid, clken, exp_sready, exp_mvalid, exp_clken);
      end
      total++;
      if (dsp_reset !== exp_dsp_reset || flush_done !== exp_fdone) begin
        bad++;
        $display("[TB] FAIL rand_ctrl cycle %0d: dsp_reset=%b flush_done=%b, required %b %b",
                 c, dsp_reset, flush_done, exp_dsp_reset, exp_fdone);
      end
      total++;
      if (stage_load !== exp_load) begin
        bad++;
        $display("[TB] FAIL rand_load cycle %0d: stage_load=%b, required %b", c, stage_load, exp_load);
      end
      total++;
      if (occupancy !== OCC_W'(exp_occ)) begin
        bad++;
        $display("[TB] FAIL rand_occ cycle %0d: occupancy=%0d, required %0d", c, occupancy, exp_occ);
      end
`ifdef DSP_CASCADE_PERF_CNT_EN
      total++;
      if (perf_beats !== mdl_beats || perf_stalls !== mdl_stalls) begin
        bad++;
        $display("[TB] FAIL rand_perf cycle %0d: beats=%0d stalls=%0d, required %0d %0d",
                 c, perf_beats, perf_stalls, mdl_beats, mdl_stalls);
      end
`endif
      advance();
    end
    aresetn = 1'b1; flush_req = 1'b0; s_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_stream();
    test_backpressure();
    test_flush();
    test_flush_empty();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
